conv_encoder_tx: RTL

//  Transmit end of the Viterbi link: rate-1/2 convolutional encoder with frame

---
 rtl/conv_encoder_tx.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/conv_encoder_tx.sv
`default_nettype none
// ============================================================================
// Module      : conv_encoder_tx
// Description : Rate-1/2 convolutional encoder with frame control; appends
//               K-1 zero-input tail symbols so every frame ends in state 0.
// Revision    : 1.0 - initial release
// ============================================================================
module conv_encoder_tx #(
    parameter int           K         = 3,
    parameter logic [K-1:0] G0        = 3'b111,
    parameter logic [K-1:0] G1        = 3'b101,
    parameter int           FRAME_LEN = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable_i,
    input  logic       d_in,
    output logic       ready_o,
    output logic       valid_o,
    output logic [1:0] d_out,
    output logic       frame_start_o,
    output logic       frame_end_o,
    output logic       busy_o
);

    localparam int BCW = $clog2(FRAME_LEN + 1);
    localparam int TCW = $clog2(K);
    localparam logic [BCW-1:0] c_last_bit  = BCW'(FRAME_LEN - 1);
    localparam logic [BCW-1:0] c_bit_one   = BCW'(1);
    localparam logic [TCW-1:0] c_last_tail = TCW'(K - 2);
    localparam logic [TCW-1:0] c_tail_one  = TCW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DATA = 2'd1,
        S_TAIL = 2'd2
    } state_t;

    state_t         r_state, w_state_next;
    logic [K-2:0]   r_sreg;
    logic [K-2:0]   w_sreg_next;
    logic [BCW-1:0] r_bit_cnt, w_bit_cnt_next;
    logic [TCW-1:0] r_tail_cnt, w_tail_cnt_next;
    logic           r_valid;
    logic [1:0]     r_dout;
    logic           r_fs;
    logic           r_fe;

    logic           w_accept;
    logic           w_bit;
    logic [K-1:0]   w_word;
    logic [1:0]     w_sym;
    logic           w_emit;
    logic           w_fs_next;
    logic           w_fe_next;

    assign ready_o  = (r_state != S_TAIL);
    assign busy_o   = (r_state != S_IDLE);
    assign w_accept = enable_i && ready_o;

    // Tail symbols flush the register with zero input regardless of d_in
    assign w_bit  = (r_state == S_TAIL) ? 1'b0 : d_in;
    assign w_word = {w_bit, r_sreg};
    assign w_sym  = {^(w_word & G0), ^(w_word & G1)};

    generate
        if (K == 2) begin : g_sr_single
            assign w_sreg_next = w_bit;
        end else begin : g_sr_multi
            assign w_sreg_next = {w_bit, r_sreg[K-2:1]};
        end
    endgenerate

    always_comb begin
        w_state_next    = r_state;
        w_bit_cnt_next  = r_bit_cnt;
        w_tail_cnt_next = r_tail_cnt;
        w_emit          = 1'b0;
        w_fs_next       = 1'b0;
        w_fe_next       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_emit          = 1'b1;
                    w_fs_next       = 1'b1;
                    w_bit_cnt_next  = c_bit_one;
                    w_tail_cnt_next = '0;
                    w_state_next    = (FRAME_LEN == 1) ? S_TAIL : S_DATA;
                end
            end
            S_DATA: begin
                if (w_accept) begin
                    w_emit         = 1'b1;
                    w_bit_cnt_next = r_bit_cnt + c_bit_one;
                    if (r_bit_cnt == c_last_bit) begin
                        w_state_next    = S_TAIL;
                        w_tail_cnt_next = '0;
                    end
                end
            end
            S_TAIL: begin
                w_emit = 1'b1;
                if (r_tail_cnt == c_last_tail) begin
                    w_fe_next       = 1'b1;
                    w_state_next    = S_IDLE;
                    w_bit_cnt_next  = '0;
                    w_tail_cnt_next = '0;
                end else begin
                    w_tail_cnt_next = r_tail_cnt + c_tail_one;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_sreg     <= '0;
            r_bit_cnt  <= '0;
            r_tail_cnt <= '0;
            r_valid    <= 1'b0;
            r_dout     <= 2'b00;
            r_fs       <= 1'b0;
            r_fe       <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_bit_cnt  <= w_bit_cnt_next;
            r_tail_cnt <= w_tail_cnt_next;
            r_valid    <= w_emit;
            r_fs       <= w_fs_next;
            r_fe       <= w_fe_next;
            if (w_emit) begin
                r_dout <= w_sym;
                r_sreg <= w_sreg_next;
            end
        end
    end

    assign valid_o       = r_valid;
    assign d_out         = r_dout;
    assign frame_start_o = r_fs;
    assign frame_end_o   = r_fe;

endmodule
`default_nettype wire
